// File: rtl/cipher_uart_tx_if.sv
// Handshake bundle between the Caesar cipher core and its UART output stage.
// Ports carried:
//   char_in     [0:7]      ASCII char from the core, bit 0 = LSB
//   char_valid             char_in valid this cycle
//   char_ready             output stage can accept a char
//   ovf_clr                clears the sticky overflow flag
//   overflow               a char was offered while char_ready was low
//   tx                     UART 8N1 line, idle high
//   busy                   frame in progress or chars still queued
//   fifo_count [ADDR_W:0]  chars waiting in the FIFO
// Modports: master = cipher core side, slave = UART stage.
interface cipher_uart_tx_if #(
    parameter int ADDR_W = 3
);
    logic [0:7]      char_in;
    logic            char_valid;
    logic            char_ready;
    logic            ovf_clr;
    logic            overflow;
    logic            tx;
    logic            busy;
    logic [ADDR_W:0] fifo_count;

    modport master (
        output char_in, char_valid, ovf_clr,
        input  char_ready, overflow, tx, busy, fifo_count
    );

    modport slave (
        input  char_in, char_valid, ovf_clr,
        output char_ready, overflow, tx, busy, fifo_count
    );
endinterface

// File: rtl/cipher_uart_tx.sv
// UART 8N1 output stage for the Caesar cipher datapath. Chars from the core
// are queued in a small FIFO and shifted out LSB first on tx.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; abandons any frame, empties FIFO
//   bus    cipher_uart_tx_if slave: char_in/char_valid/char_ready push side,
//          ovf_clr/overflow sticky flag, tx line, busy, fifo_count
module cipher_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    cipher_uart_tx_if.slave     bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [0:7]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [0:7]        mem_q [FIFO_DEPTH];

    logic              ready_s;
    logic              push_s;
    logic              pop_s;
    logic              have_s;
    logic              last_tick_s;
    logic [0:7]        head_s;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign ready_s = (count_q < (ADDR_W+1)'(FIFO_DEPTH));
    assign push_s  = bus.char_valid & ready_s;
    assign have_s  = (count_q != {(ADDR_W+1){1'b0}});
    assign head_s  = mem_q[rd_ptr_q];
    assign last_tick_s = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    assign bus.char_ready = ready_s;
    assign bus.overflow   = overflow_q;
    assign bus.tx         = tx_q;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != ST_IDLE) | have_s;

    // Frame sequencer: next state, bit timing, shift register and next tx level.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                bit_cnt_d = {CNT_W{1'b0}};
                if (have_s) begin
                    // Start bit is driven from the pop edge onward.
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_tick_s) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    idx_d     = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (last_tick_s) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (last_tick_s) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    if (have_s) begin
                        // Chain straight into the next frame, no idle gap.
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_d      = 1'b1;
                bit_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping and sticky overflow flag (set beats clear).
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (bus.char_valid & ~ready_s) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, datapath and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= {CNT_W{1'b0}};
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            count_q    <= {(ADDR_W+1){1'b0}};
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.char_in;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_cipher_uart_tx.sv
// Directed bench for cipher_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_cipher_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cipher_uart_tx_if #(.ADDR_W(AW)) ifc ();

    cipher_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The core's bus numbers bits [0:7] with bit 0 = LSB.
    task automatic set_char(input logic [7:0] a);
        for (int i = 0; i < 8; i++) ifc.char_in[i] = a[i];
    endtask

    task automatic do_reset();
        ifc.char_valid = 1'b0;
        ifc.ovf_clr    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a start bit, then samples mid-bit. gap = negedges
    // waited until tx was seen low, -1 on timeout.
    task automatic rx_frame(output logic [7:0] d, output logic stop_ok, output int gap);
        gap = 0;
        d = 8'h00;
        stop_ok = 1'b0;
        do begin
            @(negedge clk);
            gap++;
        end while (ifc.tx !== 1'b0 && gap < 200);
        if (ifc.tx !== 1'b0) begin
            gap = -1;
            return;
        end
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = ifc.tx;
        end
        repeat (CPB) @(negedge clk);
        stop_ok = (ifc.tx === 1'b1);
    endtask

    logic [7:0] d;
    logic       stop_ok;
    int         gap;
    logic [7:0] fill_c [10];
    logic [7:0] rx_d   [9];
    logic       rx_stop[9];
    int         rx_gap [9];
    int         zeros;
    int         waited;

    initial begin
        checks = 0;
        errors = 0;
        fill_c = '{8'h43, 8'h41, 8'h45, 8'h53, 8'h41, 8'h52, 8'h21, 8'h31, 8'h7A, 8'h58};
        ifc.char_in    = 8'h00;
        ifc.char_valid = 1'b0;
        ifc.ovf_clr    = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", ifc.tx, 1);
        check("rst_busy", ifc.busy, 0);
        check("rst_ready", ifc.char_ready, 1);
        check("rst_count", ifc.fifo_count, 0);
        check("rst_ovf", ifc.overflow, 0);
        rst_n = 1'b1;
        tick();
        check("idle_tx", ifc.tx, 1);

        // Single 'D'
        set_char(8'h44);
        ifc.char_valid = 1'b1;
        tick();
        ifc.char_valid = 1'b0;
        check("d_count", ifc.fifo_count, 1);
        rx_frame(d, stop_ok, gap);
        check("d_latency", gap, 2);
        check("d_data", d, 8'h44);
        check("d_stop", stop_ok, 1);
        @(negedge clk);
        check("d_busy_39", ifc.busy, 1);
        @(negedge clk);
        check("d_busy_40", ifc.busy, 0);

        // Back-to-back 'K','h'
        set_char(8'h4B);
        ifc.char_valid = 1'b1;
        tick();
        set_char(8'h68);
        tick();
        ifc.char_valid = 1'b0;
        check("kh_count_peak", ifc.fifo_count, 1);
        rx_frame(d, stop_ok, gap);
        check("k_gap", gap, 1);
        check("k_data", d, 8'h4B);
        check("k_stop", stop_ok, 1);
        rx_frame(d, stop_ok, gap);
        check("h_gap", gap, 2);
        check("h_data", d, 8'h68);
        check("h_stop", stop_ok, 1);
        check("kh_count_end", ifc.fifo_count, 0);
        @(negedge clk);
        check("kh_busy_79", ifc.busy, 1);
        @(negedge clk);
        check("kh_busy_80", ifc.busy, 0);

        // Fill: 10 pushes, 10th refused
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    set_char(fill_c[i]);
                    ifc.char_valid = 1'b1;
                    tick();
                    if (i == 8) begin
                        check("fill_count8", ifc.fifo_count, 8);
                        check("fill_ready0", ifc.char_ready, 0);
                        check("fill_ovf_before", ifc.overflow, 0);
                    end
                end
                ifc.char_valid = 1'b0;
                check("fill_ovf_set", ifc.overflow, 1);
                check("fill_refused", ifc.fifo_count, 8);
                ifc.ovf_clr = 1'b1;
                tick();
                ifc.ovf_clr = 1'b0;
                check("fill_ovf_clr", ifc.overflow, 0);
            end
            begin
                for (int j = 0; j < 9; j++) begin
                    rx_frame(rx_d[j], rx_stop[j], rx_gap[j]);
                end
            end
        join
        for (int j = 0; j < 9; j++) begin
            check($sformatf("fill_data%0d", j), rx_d[j], fill_c[j]);
            check($sformatf("fill_stop%0d", j), rx_stop[j], 1);
            if (j > 0) check($sformatf("fill_gap%0d", j), rx_gap[j], 2);
        end
        waited = 0;
        while (ifc.busy !== 1'b0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("fill_busy_end", ifc.busy, 0);
        check("fill_tx_end", ifc.tx, 1);
        check("fill_count_end", ifc.fifo_count, 0);

        // Full FIFO: push offered in the same cycle as a pop
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_char(8'h30 + 8'(i));
            ifc.char_valid = 1'b1;
            tick();
        end
        ifc.char_valid = 1'b0;
        check("full_count8", ifc.fifo_count, 8);
        repeat (32) tick();
        check("full_pre_count", ifc.fifo_count, 8);
        check("full_pre_ready", ifc.char_ready, 0);
        check("full_pre_ovf", ifc.overflow, 0);
        set_char(8'h3F);
        ifc.char_valid = 1'b1;
        tick();
        ifc.char_valid = 1'b0;
        check("full_pop_count", ifc.fifo_count, 7);
        check("full_pop_ovf", ifc.overflow, 1);
        check("full_pop_ready", ifc.char_ready, 1);

        // Reset in the middle of 'Z' with 3 queued
        do_reset();
        set_char(8'h5A);
        ifc.char_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_char(8'h61 + 8'(i));
            tick();
        end
        ifc.char_valid = 1'b0;
        repeat (4) tick();
        check("z_mid_tx", ifc.tx, 0);
        check("z_mid_count", ifc.fifo_count, 3);
        rst_n = 1'b0;
        #1;
        check("z_rst_tx", ifc.tx, 1);
        check("z_rst_count", ifc.fifo_count, 0);
        check("z_rst_busy", ifc.busy, 0);
        check("z_rst_ready", ifc.char_ready, 1);
        tick();
        rst_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (ifc.tx !== 1'b1) zeros++;
        end
        check("z_no_frames", zeros, 0);
        check("z_busy_after", ifc.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
